// File: rtl/neural_network.sv
// Fixed-weight 3-4-2 ReLU inference engine.
// Start/ready/valid handshake, one inference in flight at a time.
module neural_network (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] input_data,
  output logic [15:0] output_data,
  output logic        valid_out,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE,
    HIDDEN,
    OUTPUT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [7:0]  x0, x1, x2;
  logic        [9:0]  h0, h1, h2, h3;
  logic signed [15:0] s0, s1;
  logic               phase;

  logic signed [9:0]  e0, e1, e2;
  logic signed [9:0]  sum, nsum;
  logic signed [15:0] k0, k1, k2, k3;
  logic signed [15:0] acc0, acc1;

  function automatic logic [9:0] relu(input logic signed [9:0] v);
    return v[9] ? 10'd0 : v;
  endfunction

  function automatic logic [7:0] sat(input logic signed [15:0] v);
    if (v < 16'sd0)
      return 8'd0;
    else if (v > 16'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  assign e0   = {{2{x0[7]}}, x0};
  assign e1   = {{2{x1[7]}}, x1};
  assign e2   = {{2{x2[7]}}, x2};
  assign sum  = e0 + e1 + e2;
  assign nsum = -sum;

  assign k0 = {6'd0, h0};
  assign k1 = {6'd0, h1};
  assign k2 = {6'd0, h2};
  assign k3 = {6'd0, h3};

  assign acc0 = 16'sd7 + 16'sd11 * k0 + k1
              + 16'sd2 * k2 - k3;
  assign acc1 = 16'sd7 + 16'sd10 * k0 + 16'sd2 * k1
              + 16'sd4 * k2 - k3;

  assign ready = (state == IDLE);

  // OUTPUT spends two cycles: accumulate, then saturate and publish
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = HIDDEN;
      HIDDEN: state_next = OUTPUT;
      OUTPUT: if (phase) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x0          <= '0;
      x1          <= '0;
      x2          <= '0;
      h0          <= '0;
      h1          <= '0;
      h2          <= '0;
      h3          <= '0;
      s0          <= '0;
      s1          <= '0;
      phase       <= 1'b0;
      output_data <= '0;
      valid_out   <= 1'b0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x0 <= input_data[23:16];
            x1 <= input_data[15:8];
            x2 <= input_data[7:0];
          end
        end
        HIDDEN: begin
          h0 <= relu(sum);
          h1 <= relu(e0);
          h2 <= relu(e2);
          h3 <= relu(nsum);
        end
        OUTPUT: begin
          if (!phase) begin
            s0    <= acc0;
            s1    <= acc1;
            phase <= 1'b1;
          end else begin
            output_data <= {sat(s0), sat(s1)};
            valid_out   <= 1'b1;
            phase       <= 1'b0;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_network.sv
// Directed table-driven bench for neural_network.
// Checks handshake timing, arithmetic, saturation, abort and hold.
module tb_neural_network;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] input_data;
  logic [15:0] output_data;
  logic        valid_out;
  logic        ready;

  int checks;
  int errors;

  neural_network dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .input_data  (input_data),
    .output_data (output_data),
    .valid_out   (valid_out),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run(input logic [23:0] din,
                     input logic [15:0] exp);
    start      = 1'b1;
    input_data = din;
    tick();
    start      = 1'b0;
    input_data = ~din;
    check("ready_e1", 32'(ready), 0);
    check("valid_e1", 32'(valid_out), 0);
    tick();
    check("ready_e2", 32'(ready), 0);
    check("valid_e2", 32'(valid_out), 0);
    tick();
    check("ready_e3", 32'(ready), 0);
    check("valid_e3", 32'(valid_out), 0);
    tick();
    check("valid_e4", 32'(valid_out), 1);
    check("ready_e4", 32'(ready), 0);
    check("out_e4", 32'(output_data), 32'(exp));
    tick();
    check("valid_e5", 32'(valid_out), 0);
    check("ready_e5", 32'(ready), 1);
    check("out_e5", 32'(output_data), 32'(exp));
  endtask

  int pulses;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    input_data = '0;

    vecs[0] = '{24'h010203, {8'd80,  8'd81}};
    vecs[1] = '{24'h030201, {8'd78,  8'd77}};
    vecs[2] = '{24'h000000, {8'd7,   8'd7}};
    vecs[3] = '{24'hFFFEFD, {8'd1,   8'd1}};
    vecs[4] = '{24'h0A00F6, {8'd17,  8'd27}};
    vecs[5] = '{24'h7F7F7F, {8'd255, 8'd255}};
    vecs[6] = '{24'h808080, {8'd0,   8'd0}};

    tick();
    tick();
    rst = 1'b0;
    check("rst_out", 32'(output_data), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_ready", 32'(ready), 1);

    for (int i = 0; i < 7; i++)
      run(vecs[i].din, vecs[i].exp);

    // Second start two cycles into a run must be ignored
    start      = 1'b1;
    input_data = 24'h030201;
    tick();
    start      = 1'b0;
    tick();
    start      = 1'b1;
    input_data = 24'h7F7F7F;
    tick();
    start      = 1'b0;
    input_data = '0;
    tick();
    check("ign_valid", 32'(valid_out), 1);
    check("ign_out", 32'(output_data), 32'({8'd78, 8'd77}));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_out) pulses++;
    end
    check("ign_pulses", 32'(pulses), 0);
    check("ign_ready", 32'(ready), 1);
    check("ign_hold", 32'(output_data), 32'({8'd78, 8'd77}));

    // Reset while in OUTPUT aborts the run
    start      = 1'b1;
    input_data = 24'h010203;
    tick();
    start      = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(valid_out), 0);
    check("abort_out", 32'(output_data), 0);
    check("abort_ready", 32'(ready), 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_out) pulses++;
    end
    check("abort_pulses", 32'(pulses), 0);
    run(24'h010203, {8'd80, 8'd81});

    // Result holds while inputs wander without start
    for (int i = 0; i < 10; i++) begin
      input_data = 24'($urandom);
      tick();
      check("hold_out", 32'(output_data),
            32'({8'd80, 8'd81}));
      check("hold_valid", 32'(valid_out), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
